// File: rtl/frame_capture_buf_pkg.sv
// Shared state encoding and 640x480 defaults for the frame capture buffer.
// Imported by the RTL and by benches so everyone agrees on the FSM encoding.
package frame_capture_buf_pkg;

    localparam int DEF_PIX_W     = 8;
    localparam int DEF_FRAME_PIX = 307200;
    localparam int DEF_ADDR_W    = 19;
    localparam int DEF_LATENCY   = 537;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_CAPT = 2'd2,
        ST_READ = 2'd3
    } frameState_t;

    // Width of the latency counter; it only ever reaches LATENCY-2.
    function automatic int latCntWidth(input int latency);
        return (latency > 2) ? $clog2(latency) : 1;
    endfunction

endpackage

// File: rtl/frame_capture_buf_ram.sv
// Simple dual-port frame store: one write port, one registered read port with 1-cycle latency.
// Written to infer block RAM; contents are never reset.
module frame_capture_buf_ram #(
    parameter int PIX_W  = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              iClk,
    input  logic              iWe,
    input  logic [ADDR_W-1:0] iWrAddr,
    input  logic [PIX_W-1:0]  iWrData,
    input  logic              iRe,
    input  logic [ADDR_W-1:0] iRdAddr,
    output logic [PIX_W-1:0]  oRdData
);

    logic [PIX_W-1:0] mem [DEPTH];

    always_ff @(posedge iClk) begin
        if (iWe) begin
            mem[iWrAddr] <= iWrData;
        end
        if (iRe) begin
            oRdData <= mem[iRdAddr];
        end
    end

endmodule

// File: rtl/frame_capture_buf.sv
// Captures one processed frame after the pipeline fill latency, then replays it over valid/ready.
// Optional checksum ports oCksum/oCksumVld exist only when FRAME_CKSUM_EN is defined.
module frame_capture_buf
    import frame_capture_buf_pkg::*;
#(
    parameter int PIX_W     = DEF_PIX_W,
    parameter int FRAME_PIX = DEF_FRAME_PIX,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int LATENCY   = DEF_LATENCY
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iStart,
    input  logic [PIX_W-1:0] iData,
    output logic [PIX_W-1:0] oRdData,
    output logic             oRdValid,
    input  logic             iRdReady,
    output logic             oRdLast,
    output logic             oBusy,
    output logic             oOverrun,
`ifdef FRAME_CKSUM_EN
    output logic [31:0]      oCksum,
    output logic             oCksumVld,
`endif
    output logic [1:0]       oDbgState
);

    localparam int LAT_W   = latCntWidth(LATENCY);
    localparam int LAT_END = (LATENCY >= 2) ? LATENCY - 2 : 0;
    localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(LAT_END);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIX - 1);

    frameState_t       state;
    logic [LAT_W-1:0]  latCnt;
    logic [ADDR_W-1:0] wrAddr;
    logic [ADDR_W-1:0] rdAddr;
    logic              rdDone;

    logic              inflight;
    logic              inflightLast;
    logic [PIX_W-1:0]  skidData;
    logic              skidValid;
    logic              skidLast;

    logic              startAccept;
    logic              enterCapt;
    logic              ramWe;
    logic [ADDR_W-1:0] ramWa;
    logic [PIX_W-1:0]  ramQ;
    logic              popNow;
    logic              issue;
    logic [1:0]        occ;

    // Start is counted as cycle 0 of the latency, so the first captured pixel lands exactly
    // LATENCY cycles after iStart; with LATENCY=0 the start cycle itself writes pixel 0.
    assign startAccept = iStart && (state == ST_IDLE);
    assign enterCapt   = ((state == ST_WAIT) && (latCnt == LAT_LAST)) ||
                         (startAccept && (LATENCY == 1));
    assign ramWe       = (state == ST_CAPT) || (startAccept && (LATENCY == 0));
    assign ramWa       = (state == ST_CAPT) ? wrAddr : '0;

    // Read port handshake: a pixel moves when oRdValid && iRdReady on a rising edge; while
    // oRdValid is high and iRdReady low, oRdData/oRdLast hold and oRdValid never drops.
    assign popNow = oRdValid && iRdReady;
    assign occ    = 2'(oRdValid) + 2'(skidValid) + 2'(inflight);
    assign issue  = (state == ST_READ) && !rdDone &&
                    ((occ < 2'd2) || (popNow && (occ == 2'd2)));

    assign oBusy     = (state != ST_IDLE);
    assign oDbgState = state;

    frame_capture_buf_ram #(
        .PIX_W (PIX_W),
        .DEPTH (FRAME_PIX),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .iClk   (iClk),
        .iWe    (ramWe),
        .iWrAddr(ramWa),
        .iWrData(iData),
        .iRe    (issue),
        .iRdAddr(rdAddr),
        .oRdData(ramQ)
    );

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state    <= ST_IDLE;
            latCnt   <= '0;
            wrAddr   <= '0;
            rdAddr   <= '0;
            rdDone   <= 1'b0;
            oOverrun <= 1'b0;
        end else begin
            if (iStart) begin
                oOverrun <= (state != ST_IDLE);
            end
            case (state)
                ST_IDLE: begin
                    if (iStart) begin
                        latCnt <= '0;
                        if (LATENCY == 0) begin
                            state  <= ST_CAPT;
                            wrAddr <= ADDR_W'(1);
                        end else if (LATENCY == 1) begin
                            state  <= ST_CAPT;
                            wrAddr <= '0;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (latCnt == LAT_LAST) begin
                        state  <= ST_CAPT;
                        wrAddr <= '0;
                    end else begin
                        latCnt <= latCnt + LAT_W'(1);
                    end
                end
                ST_CAPT: begin
                    if (wrAddr == LAST_ADDR) begin
                        state  <= ST_READ;
                        rdAddr <= '0;
                        rdDone <= 1'b0;
                    end else begin
                        wrAddr <= wrAddr + ADDR_W'(1);
                    end
                end
                ST_READ: begin
                    if (issue) begin
                        if (rdAddr == LAST_ADDR) begin
                            rdDone <= 1'b1;
                        end else begin
                            rdAddr <= rdAddr + ADDR_W'(1);
                        end
                    end
                    if (popNow && oRdLast) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Output register is the head of a 2-deep queue; the skid slot absorbs the one read
    // already in flight when the host stalls, so issue is throttled on total occupancy.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            oRdData      <= '0;
            oRdValid     <= 1'b0;
            oRdLast      <= 1'b0;
            skidData     <= '0;
            skidValid    <= 1'b0;
            skidLast     <= 1'b0;
            inflight     <= 1'b0;
            inflightLast <= 1'b0;
        end else begin
            inflight     <= issue;
            inflightLast <= issue && (rdAddr == LAST_ADDR);
            if (popNow || !oRdValid) begin
                if (skidValid) begin
                    oRdData   <= skidData;
                    oRdLast   <= skidLast;
                    oRdValid  <= 1'b1;
                    skidValid <= inflight;
                    skidData  <= ramQ;
                    skidLast  <= inflightLast;
                end else if (inflight) begin
                    oRdData  <= ramQ;
                    oRdLast  <= inflightLast;
                    oRdValid <= 1'b1;
                end else begin
                    oRdValid <= 1'b0;
                    oRdLast  <= 1'b0;
                end
            end else if (inflight) begin
                skidData  <= ramQ;
                skidLast  <= inflightLast;
                skidValid <= 1'b1;
            end
        end
    end

`ifdef FRAME_CKSUM_EN
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            oCksum    <= '0;
            oCksumVld <= 1'b0;
        end else begin
            oCksumVld <= (state == ST_CAPT) && (wrAddr == LAST_ADDR);
            if (startAccept && (LATENCY == 0)) begin
                oCksum <= 32'(iData);
            end else if (enterCapt) begin
                oCksum <= '0;
            end else if (state == ST_CAPT) begin
                oCksum <= oCksum + 32'(iData);
            end
        end
    end
`endif

    a_stall_stable: assert property (@(posedge iClk) disable iff (!iRst)
        (oRdValid && !iRdReady) |=> (oRdValid && $stable(oRdData) && $stable(oRdLast)));

    a_no_overflow: assert property (@(posedge iClk) disable iff (!iRst)
        !(inflight && skidValid && oRdValid && !popNow));

endmodule

// File: tb/tb_frame_capture_buf.sv
// Directed bench for frame_capture_buf: one instance with LATENCY=4 and one with LATENCY=0.
// Checksum checks are compiled in only when FRAME_CKSUM_EN is defined.
module tb_frame_capture_buf;
    import frame_capture_buf_pkg::*;

    localparam int FRAME_PIX = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       start   [2];
    logic [7:0] data    [2];
    logic       rdy     [2];
    logic [7:0] rdData  [2];
    logic       rdValid [2];
    logic       rdLast  [2];
    logic       busy    [2];
    logic       ovr     [2];
    logic [1:0] dbgState[2];
`ifdef FRAME_CKSUM_EN
    logic [31:0] cksum   [2];
    logic        cksumVld[2];
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Scoreboard: expected replay pixels tagged with the instance index in bit 8.
    logic [8:0] exp_q[$];
    logic [8:0] got_q[$];

    int lats   [2] = '{4, 0};
    bit mBusy  [2] = '{0, 0};
    bit mOvr   [2] = '{0, 0};
    int mStart [2] = '{0, 0};
    int mDel   [2] = '{0, 0};
    int mSum   [2] = '{0, 0};
    int firstV [2] = '{-1, -1};
    int lastCnt[2] = '{0, 0};
    int vldCnt [2] = '{0, 0};

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    frame_capture_buf #(.PIX_W(8), .FRAME_PIX(FRAME_PIX), .ADDR_W(4), .LATENCY(4)) u_dut (
        .iClk(clk), .iRst(rst), .iStart(start[0]), .iData(data[0]),
        .oRdData(rdData[0]), .oRdValid(rdValid[0]), .iRdReady(rdy[0]), .oRdLast(rdLast[0]),
        .oBusy(busy[0]), .oOverrun(ovr[0]),
`ifdef FRAME_CKSUM_EN
        .oCksum(cksum[0]), .oCksumVld(cksumVld[0]),
`endif
        .oDbgState(dbgState[0])
    );

    frame_capture_buf #(.PIX_W(8), .FRAME_PIX(FRAME_PIX), .ADDR_W(4), .LATENCY(0)) u_dut_lat0 (
        .iClk(clk), .iRst(rst), .iStart(start[1]), .iData(data[1]),
        .oRdData(rdData[1]), .oRdValid(rdValid[1]), .iRdReady(rdy[1]), .oRdLast(rdLast[1]),
        .oBusy(busy[1]), .oOverrun(ovr[1]),
`ifdef FRAME_CKSUM_EN
        .oCksum(cksum[1]), .oCksumVld(cksumVld[1]),
`endif
        .oDbgState(dbgState[1])
    );

    task automatic check(input string name, input int d, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d cycle=%0d got=0x%0h exp=0x%0h", name, d, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- model + compare (every cycle, both instances) ----------------
    always @(negedge clk) begin : mon
        int lat;
        bit ev;
        bit evBusy;
        bit evCk;
        for (int d = 0; d < 2; d++) begin
            lat    = lats[d];
            evBusy = rst && mBusy[d];
            ev     = evBusy && (cyc >= mStart[d] + lat + FRAME_PIX + 2);
            evCk   = evBusy && (cyc == mStart[d] + lat + FRAME_PIX);
            check("busy", d, 32'(busy[d]), 32'(evBusy));
            check("valid", d, 32'(rdValid[d]), 32'(ev));
            check("last", d, 32'(rdLast[d]), 32'(ev && (mDel[d] == FRAME_PIX - 1)));
            check("overrun", d, 32'(ovr[d]), 32'(rst && mOvr[d]));
            if (ev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL underflow dut%0d cycle=%0d got=0x%0h exp=none", d, cyc, rdData[d]);
                end else begin
                    check("data", d, 32'({d[0], rdData[d]}), 32'(exp_q[0]));
                end
            end
`ifdef FRAME_CKSUM_EN
            check("cksum_vld", d, 32'(cksumVld[d]), 32'(evCk));
            if (evCk) check("cksum", d, cksum[d], 32'(mSum[d]));
            if (cksumVld[d]) vldCnt[d]++;
`endif
            if (rst && rdValid[d] && firstV[d] < 0) firstV[d] = cyc;

            if (!rst) begin
                mBusy[d] = 1'b0;
                mOvr[d]  = 1'b0;
                mDel[d]  = 0;
                if (d == 1) exp_q.delete();
            end else begin
                if (start[d]) begin
                    if (mBusy[d]) begin
                        mOvr[d] = 1'b1;
                    end else begin
                        mBusy[d]  = 1'b1;
                        mStart[d] = cyc;
                        mOvr[d]   = 1'b0;
                        mSum[d]   = 0;
                    end
                end
                if (mBusy[d] && (cyc - mStart[d] >= lat) && (cyc - mStart[d] < lat + FRAME_PIX)) begin
                    exp_q.push_back({d[0], data[d]});
                    mSum[d] += int'(data[d]);
                end
                if (ev && rdy[d]) begin
                    got_q.push_back({d[0], rdData[d]});
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    if (rdLast[d]) lastCnt[d]++;
                    mDel[d]++;
                    if (mDel[d] == FRAME_PIX) begin
                        mBusy[d] = 1'b0;
                        mDel[d]  = 0;
                    end
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic run_frame(input int d, input logic [7:0] base, input bit fixedPix,
                             input bit bp, input int ovrAt, output int sCyc);
        int lat;
        bit done;
        logic [3:0] pat;
        lat  = lats[d];
        done = 1'b0;
        pat  = 4'b1001;
        got_q.delete();
        firstV[d]  = -1;
        lastCnt[d] = 0;
        vldCnt[d]  = 0;
        sCyc = cyc;
        for (int j = 0; j < 400; j++) begin
            start[d] = (j == 0) || (ovrAt > 0 && j == ovrAt);
            if (j >= lat && j < lat + FRAME_PIX) data[d] = fixedPix ? base : base + 8'(j - lat);
            else data[d] = 8'($urandom_range(0, 255));
            if (!bp || j < lat + FRAME_PIX + 2) rdy[d] = 1'b1;
            else if (j < lat + FRAME_PIX + 6) rdy[d] = pat[j - lat - FRAME_PIX - 2];
            else rdy[d] = 1'($urandom_range(0, 1));
            tick();
            if (j > lat + FRAME_PIX && !busy[d]) begin
                done = 1'b1;
                break;
            end
        end
        start[d] = 1'b0;
        rdy[d]   = 1'b1;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL timeout dut%0d cycle=%0d got=busy exp=idle", d, cyc);
        end
    endtask

    task automatic check_replay(input int d, input logic [7:0] base, input bit fixedPix);
        check("count", d, 32'(got_q.size()), 32'(FRAME_PIX));
        for (int k = 0; k < got_q.size() && k < FRAME_PIX; k++) begin
            check("replay", d, 32'(got_q[k]), 32'({d[0], (fixedPix ? base : base + 8'(k))}));
        end
        check("last_cnt", d, 32'(lastCnt[d]), 32'd1);
    endtask

    initial begin
        int s;
        rst      = 1'b0;
        start[0] = 1'b0; start[1] = 1'b0;
        data[0]  = 8'h00; data[1] = 8'h00;
        rdy[0]   = 1'b1; rdy[1] = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        tick();

        // reset state
        check("rst_state", 0, 32'(dbgState[0]), 32'(ST_IDLE));
        check("rst_rddata", 0, 32'(rdData[0]), 32'h0);
        check("rst_valid", 1, 32'(rdValid[1]), 32'h0);

        // 1: reset asserted while waiting out the latency
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        tick();
        check("wait_busy", 0, 32'(busy[0]), 32'h1);
        rst = 1'b0;
        #1;
        check("midrst_busy", 0, 32'(busy[0]), 32'h0);
        check("midrst_valid", 0, 32'(rdValid[0]), 32'h0);
        check("midrst_state", 0, 32'(dbgState[0]), 32'(ST_IDLE));
        tick();
        rst = 1'b1;
        tick();
        run_frame(0, 8'h10, 1'b0, 1'b0, 0, s);
        check_replay(0, 8'h10, 1'b0);

        // 2: basic frame, pixel index as data
        run_frame(0, 8'h00, 1'b0, 1'b0, 0, s);
        check_replay(0, 8'h00, 1'b0);
        check("first_vld", 0, 32'(firstV[0]), 32'(s + 22));

        // 3: backpressure
        run_frame(0, 8'h30, 1'b0, 1'b1, 0, s);
        check_replay(0, 8'h30, 1'b0);

        // 4: overrun during capture, then cleared by the next start
        run_frame(0, 8'h00, 1'b0, 1'b0, 10, s);
        check_replay(0, 8'h00, 1'b0);
        check("ovr_set", 0, 32'(ovr[0]), 32'h1);
        run_frame(0, 8'h50, 1'b0, 1'b0, 0, s);
        check("ovr_clr", 0, 32'(ovr[0]), 32'h0);
        check_replay(0, 8'h50, 1'b0);

        // 5: zero latency
        run_frame(1, 8'hA0, 1'b0, 1'b0, 0, s);
        if (got_q.size() > 0) check("first_pix", 1, 32'(got_q[0][7:0]), 32'hA0);
        check("first_vld", 1, 32'(firstV[1]), 32'(s + 18));
        check_replay(1, 8'hA0, 1'b0);

`ifdef FRAME_CKSUM_EN
        // 6: checksum of an all-0xFF frame
        run_frame(0, 8'hFF, 1'b1, 1'b0, 0, s);
        check("cksum_val", 0, cksum[0], 32'h0000_0FF0);
        check("cksum_pulses", 0, 32'(vldCnt[0]), 32'd1);
        check_replay(0, 8'hFF, 1'b1);
`endif

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
